// File: rtl/apb_master_ctrl.sv
// APB master: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers to one of NSLV address-decoded slaves. It reports pslverr, aborts
// on a wait-state timeout and holds each response until it is consumed.
module apb_master_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    // command stream
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    // response stream
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    // APB fabric
    output logic [NSLV-1:0]          psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [NSLV*DATA_W-1:0]   prdata,
    input  logic [NSLV-1:0]          pready,
    input  logic [NSLV-1:0]          pslverr
);

    // Slave index width; a single slave uses a 1-bit index tied to zero.
    localparam int unsigned SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    // Wait counter wide enough to hold TIMEOUT.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_next;

    logic [NSLV-1:0]     psel_next;
    logic                penable_next;
    logic                pwrite_next;
    logic [ADDR_W-1:0]   paddr_next;
    logic [DATA_W-1:0]   pwdata_next;
    logic                rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_next;
    logic                rsp_err_next;
    logic                rsp_timeout_next;

    logic [SEL_W-1:0]    cmd_sel;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    // Slave index from the top address bits of the incoming command.
    always_comb begin
        cmd_sel = '0;
        if (NSLV > 1) begin
            cmd_sel = SEL_W'(cmd_addr >> (ADDR_W - SEL_W));
        end
    end

    // Pick the selected slave's response lines using the one-hot psel mask.
    always_comb begin
        sel_ready = |(pready & psel);
        sel_err   = |(pslverr & psel);
        sel_rdata = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (psel[k]) begin
                sel_rdata = sel_rdata | prdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Abort when the wait cycle now ending is the TIMEOUT-th one.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT));
        end
    end

    // Accepting commands only in IDLE; held low for the whole reset pulse.
    always_comb begin
        cmd_ready = (state == IDLE) && !preset;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next       = state;
        wait_next        = wait_cnt;
        psel_next        = '0;
        penable_next     = 1'b0;
        pwrite_next      = 1'b0;
        paddr_next       = '0;
        pwdata_next      = '0;
        rsp_valid_next   = rsp_valid;
        rsp_rdata_next   = rsp_rdata;
        rsp_err_next     = rsp_err;
        rsp_timeout_next = rsp_timeout;

        case (state)
            IDLE: begin
                rsp_valid_next   = 1'b0;
                rsp_rdata_next   = '0;
                rsp_err_next     = 1'b0;
                rsp_timeout_next = 1'b0;
                if (cmd_valid) begin
                    state_next  = SETUP;
                    wait_next   = '0;
                    psel_next   = NSLV'(1) << cmd_sel;
                    pwrite_next = cmd_write;
                    paddr_next  = cmd_addr;
                    pwdata_next = cmd_write ? cmd_wdata : '0;
                end
            end

            SETUP: begin
                state_next   = ACCESS;
                psel_next    = psel;
                penable_next = 1'b1;
                pwrite_next  = pwrite;
                paddr_next   = paddr;
                pwdata_next  = pwdata;
            end

            ACCESS: begin
                if (sel_ready) begin
                    // A ready on the timeout edge still completes normally.
                    state_next       = RESP;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = sel_err;
                    rsp_timeout_next = 1'b0;
                    rsp_rdata_next   = (!pwrite && !sel_err) ? sel_rdata : '0;
                end else if (timeout_hit) begin
                    state_next       = RESP;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
                end else begin
                    psel_next    = psel;
                    penable_next = 1'b1;
                    pwrite_next  = pwrite;
                    paddr_next   = paddr;
                    pwdata_next  = pwdata;
                    wait_next    = (wait_cnt == CNT_MAX) ? wait_cnt
                                                         : wait_cnt + CNT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next       = IDLE;
                    rsp_valid_next   = 1'b0;
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b0;
                    rsp_timeout_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Registered APB and response outputs; reset clears them immediately.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel        <= '0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            psel        <= psel_next;
            penable     <= penable_next;
            pwrite      <= pwrite_next;
            paddr       <= paddr_next;
            pwdata      <= pwdata_next;
            rsp_valid   <= rsp_valid_next;
            rsp_rdata   <= rsp_rdata_next;
            rsp_err     <= rsp_err_next;
            rsp_timeout <= rsp_timeout_next;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: a driver issues commands, a slave model plays
// the APB fabric from the transaction plan, and a monitor scores responses
// against a reference model of the expected outcome.
module tb_apb_master_ctrl;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NSLV    = 4;
    localparam int unsigned TIMEOUT = 8;

    logic                   pclk = 1'b0;
    logic                   preset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [DATA_W-1:0]      cmd_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   rsp_timeout;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;

    apb_master_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSLV   (NSLV),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    // One planned transfer: command plus how the addressed slave behaves.
    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;   // ACCESS cycles with pready low before pready
        bit          err;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          lat;     // cycles from accepting edge to rsp_valid
    } exp_t;

    txn_t slave_q[$];
    exp_t exp_q[$];
    int   acc_q[$];

    int n_chk  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int bp_cnt = 0;
    bit in_xfer = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int slave_of(input logic [15:0] a);
        return int'(a) / (65536 / NSLV);
    endfunction

    function automatic bit times_out(input txn_t t);
        return (TIMEOUT != 0) && (t.waits >= int'(TIMEOUT));
    endfunction

    function automatic int pen_cycles(input txn_t t);
        return times_out(t) ? int'(TIMEOUT) : t.waits + 1;
    endfunction

    // Reference outcome of a transfer.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.to    = times_out(t);
        e.err   = e.to ? 1'b1 : t.err;
        e.rdata = (e.to || t.write || t.err) ? 32'h0 : t.rdata;
        e.lat   = 1 + pen_cycles(t);
        return e;
    endfunction

    function automatic txn_t mk(input bit w, input logic [15:0] a, input logic [31:0] wd,
                                input int waits, input bit err, input logic [31:0] rd);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.waits = waits; t.err = err; t.rdata = rd;
        return t;
    endfunction

    // Offer a command at a negedge and wait (bounded) until it is accepted.
    task automatic issue(input txn_t t, input bit expect_rsp);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        slave_q.push_back(t);
        if (expect_rsp) exp_q.push_back(model(t));
        while (!cmd_ready && guard < 300) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_bound", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
        end else begin
            @(posedge pclk);
            @(negedge pclk);
            if (expect_rsp) acc_q.push_back(cyc);
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 16'($urandom);
            cmd_wdata = $urandom;
        end
    endtask

    // Check APB address/data phase fields against the planned transfer.
    task automatic check_bus(input txn_t t, input string ph);
        logic [NSLV-1:0] ep;
        ep = '0;
        ep[slave_of(t.addr)] = 1'b1;
        chk({ph, "_psel"},   64'(psel),   64'(ep));
        chk({ph, "_paddr"},  64'(paddr),  64'(t.addr));
        chk({ph, "_pwrite"}, 64'(pwrite), 64'(t.write));
        chk({ph, "_pwdata"}, 64'(pwdata), 64'(t.write ? t.wdata : 32'h0));
    endtask

    // APB slave fabric model: random noise on unselected lines, planned
    // behaviour on the selected slave.
    initial begin : slave_model
        txn_t st;
        int   acc_cnt = 0;
        int   slv;
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        forever begin
            @(negedge pclk);
            pready  = NSLV'($urandom);
            pslverr = NSLV'($urandom);
            for (int k = 0; k < int'(NSLV); k++) prdata[k*32 +: 32] = $urandom;
            if (!preset) begin
                if (psel != '0 && !penable) begin
                    chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
                    if (in_xfer || slave_q.size() == 0) begin
                        chk("unexpected_setup", 64'(1), 64'(0));
                    end else begin
                        st      = slave_q.pop_front();
                        in_xfer = 1'b1;
                        acc_cnt = 0;
                        check_bus(st, "setup");
                    end
                end else if (psel != '0 && penable) begin
                    if (!in_xfer) begin
                        chk("access_without_setup", 64'(1), 64'(0));
                    end else begin
                        acc_cnt++;
                        check_bus(st, "access");
                        slv = slave_of(st.addr);
                        pready[slv] = 1'b0;
                        if (acc_cnt == st.waits + 1) begin
                            pready[slv]           = 1'b1;
                            pslverr[slv]          = st.err;
                            prdata[slv*32 +: 32]  = st.rdata;
                        end
                    end
                end else begin
                    chk("idle_bus_zero", 64'({penable, pwrite, paddr, pwdata}), 64'(0));
                    if (in_xfer) begin
                        chk("penable_cycles", 64'(acc_cnt), 64'(pen_cycles(st)));
                        in_xfer = 1'b0;
                    end
                end
            end
        end
    end

    // Response monitor: pops the expected outcome when a new response appears
    // and re-checks it every cycle it is held; also drives rsp_ready.
    initial begin : monitor
        exp_t cur;
        bit   have_cur   = 1'b0;
        bit   prev_valid = 1'b0;
        int   a;
        rsp_ready = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                prev_valid = 1'b0;
                rsp_ready  = 1'b0;
            end else begin
                if (rsp_valid) begin
                    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'(0));
                    if (!(prev_valid && !rsp_ready)) begin
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            chk("unexpected_rsp", 64'(1), 64'(0));
                            have_cur = 1'b0;
                        end else begin
                            cur      = exp_q.pop_front();
                            a        = acc_q.pop_front();
                            have_cur = 1'b1;
                            chk("rsp_latency", 64'(cyc - a), 64'(cur.lat));
                        end
                    end
                    if (have_cur) begin
                        chk("rsp_rdata",   64'(rsp_rdata),   64'(cur.rdata));
                        chk("rsp_err",     64'(rsp_err),     64'(cur.err));
                        chk("rsp_timeout", 64'(rsp_timeout), 64'(cur.to));
                    end
                end
                prev_valid = rsp_valid;
                if (rsp_valid && bp_cnt > 0) begin
                    rsp_ready = 1'b0;
                    bp_cnt--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        txn_t t;
        int   r;
        int   guard;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge pclk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("reset_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'(0));
        preset = 1'b0;
        #1;
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge pclk);

        // Directed scenarios.
        issue(mk(1'b1, 16'h1234, 32'hDEADBEEF, 0, 1'b0, 32'h0), 1'b1);
        issue(mk(1'b0, 16'h0040, 32'h0, 3, 1'b0, 32'hCAFEF00D), 1'b1);
        issue(mk(1'b0, 16'hC010, 32'h0, 1, 1'b1, 32'h12345678), 1'b1);
        issue(mk(1'b0, 16'h8000, 32'h0, 100, 1'b0, 32'h5555AAAA), 1'b1);
        issue(mk(1'b1, 16'h4004, 32'h01020304, 7, 1'b0, 32'h0), 1'b1);
        issue(mk(1'b0, 16'h4008, 32'h0, 8, 1'b0, 32'h77778888), 1'b1);
        issue(mk(1'b0, 16'h2222, 32'h0, 7, 1'b0, 32'h9ABCDEF0), 1'b1);
        bp_cnt = 5;
        issue(mk(1'b0, 16'h8888, 32'h0, 0, 1'b0, 32'hA5A5A5A5), 1'b1);
        issue(mk(1'b1, 16'hF000, 32'h13579BDF, 2, 1'b0, 32'h0), 1'b1);

        // Reset during the second wait cycle of a read.
        issue(mk(1'b0, 16'h4100, 32'h0, 6, 1'b0, 32'h11112222), 1'b0);
        @(posedge pclk);
        @(posedge pclk);
        #2;
        chk("pre_reset_penable", 64'(penable), 64'(1));
        preset = 1'b1;
        #1;
        chk("async_reset_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 64'(0));
        chk("async_reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'(0));
        chk("async_reset_cmd_ready", 64'(cmd_ready), 64'(0));
        in_xfer = 1'b0;
        slave_q.delete();
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        #1;
        chk("release_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("release_no_rsp", 64'(rsp_valid), 64'(0));
        @(negedge pclk);
        issue(mk(1'b1, 16'h0010, 32'hFEEDFACE, 0, 1'b0, 32'h0), 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            t.write = 1'($urandom);
            t.addr  = 16'($urandom);
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.err   = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            if (r < 5)       t.waits = 0;
            else if (r < 8)  t.waits = $urandom_range(1, 4);
            else if (r == 8) t.waits = $urandom_range(6, 8);
            else             t.waits = $urandom_range(9, 12);
            if ($urandom_range(0, 7) == 0) bp_cnt = $urandom_range(1, 6);
            issue(t, 1'b1);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge pclk);
            guard++;
        end
        chk("responses_drained", 64'(exp_q.size()), 64'(0));
        repeat (5) @(negedge pclk);
        chk("slave_plan_drained", 64'(slave_q.size()), 64'(0));
        chk("final_idle_bus", 64'({psel, penable}), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised, synthesisable APB master that turns a valid/ready command stream into APB SETUP/ACCESS transfers to one of NSLV slaves. It replaces the task-driven master used in the APB benches, adding address-decoded slave select, pslverr reporting, wait-state timeout and a held response port. It sits between an internal requester (CPU bridge, DMA, or bench sequencer) and the APB slave fabric.

## Interface
- ADDR_W, 16, paddr width.
- DATA_W, 32, pwdata/prdata width.
- NSLV, 1, number of slaves; power of 2, 1..16.
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout.
- pclk  in  1  clock, all logic on rising edge.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; top log2(NSLV) bits select the slave.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  pslverr sampled high, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  ACCESS phase.
- pwrite  out  1  transfer direction.
- paddr  out  ADDR_W  transfer address.
- pwdata  out  DATA_W  write data; 0 for reads.
- prdata  in  NSLV*DATA_W  slave k read data in bits [k*DATA_W +: DATA_W].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1; on cmd_valid, register write/addr/wdata and the slave index. Go to SETUP.
- SETUP: psel[idx]=1, penable=0, and pwrite/paddr/pwdata driven from the registers. Go to ACCESS unconditionally.
- ACCESS: psel[idx]=1, penable=1, and all address/data outputs held stable. Only the selected slave's pready, pslverr and prdata are used; the others are ignored.
  - If pready[idx]=1: capture prdata (reads only) and pslverr[idx]. Go to RESP.
  - Otherwise the wait counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT, abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
- RESP: rsp_valid=1. psel, penable, pwrite, paddr and pwdata are all 0. On rsp_ready, go to IDLE.
- In IDLE, psel, penable, pwrite, paddr and pwdata are 0; the response outputs are 0.
- pslverr on a read forces rsp_rdata=0.
- The wait counter is ceil(log2(TIMEOUT+1)) bits wide, cleared on entry to SETUP, and saturates.
- Reset: asynchronous and immediate from any state, including mid-ACCESS. State goes to IDLE, every output goes to 0, and cmd_ready=1 once preset deasserts. No response is generated for an aborted transfer.

## Timing
- Command accepted at edge T. SETUP is visible T..T+1, ACCESS from T+1.
- If ACCESS completes at edge T+2+W (W = wait cycles), rsp_valid rises after that edge.
- Minimum of 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP) with W=0 and rsp_ready held high.
- cmd_ready is low from SETUP through RESP, so there is no overlap or pipelining.
- A timeout aborts at the edge ending the TIMEOUT-th wait cycle; penable is high for exactly TIMEOUT cycles.
- A pready arriving on the same edge as the timeout wins: it is a normal completion, not a timeout.
- paddr, pwrite, pwdata and psel are constant from SETUP through the last ACCESS cycle.
- Responses are held: rsp_* stay stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- **Zero-wait write.** Write addr 0x1234, data 0xDEADBEEF, NSLV=1, pready tied high. Expect psel high for 2 cycles, penable high for 1, and rsp_valid with rsp_err=0 on cycle 4.
- **Read with 3 waits.** Read addr 0x0040, pready high on the 4th ACCESS cycle with prdata 0xCAFEF00D. Expect rsp_rdata=0xCAFEF00D and penable high for 4 cycles.
- **Decode and pslverr.** NSLV=4, read addr 0xC010. Expect psel=4'b1000. pslverr[3]=1 at pready gives rsp_err=1 and rsp_rdata=0. Driving pready[0] alone has no effect.
- **Timeout.** TIMEOUT=8, pready held low. Expect an abort after 8 ACCESS cycles with rsp_err=1 and rsp_timeout=1, psel low in RESP, and the next command accepted after rsp_ready. Repeat with pready arriving on cycle 8: normal completion.
- **Response backpressure.** Hold rsp_ready low for 5 cycles. rsp_* must stay stable and cmd_ready=0; a command offered during this time is accepted only after the handshake.
- **Reset mid-ACCESS.** Assert preset during a 2nd wait cycle. All outputs must be 0 asynchronously and no rsp_valid is produced. After release, a new write completes normally.
